wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Shares the register file's single write port between two writeback sources: the memory/load path (port A, high priority, never stalled) and the ALU path (port B, low priority, valid/ready). Port B writes that lose arbitration wait in a small in-order queue. A queued B write is squashed when a younger A write targets the same register. The block drives the register file's `RegWrite`/`write_address`/`write_data` from registered outputs and exports a pending-write mask for hazard detection in decode.

## Interface
- `WIDTH`, 16, data width of a register.
- `N_REGS`, 8, number of architectural registers; address width `AW = $clog2(N_REGS)`.
- `DEPTH`, 2, port B queue depth (≥1).
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  port A write request; always accepted (no ready).
- `a_addr`  in  AW  port A destination register.
- `a_data`  in  WIDTH  port A write data.
- `b_valid`  in  1  port B write request.
- `b_ready`  out  1  port B can accept this cycle.
- `b_addr`  in  AW  port B destination register.
- `b_data`  in  WIDTH  port B write data.
- `RegWrite`  out  1  register-file write enable (registered).
- `write_address`  out  AW  register-file write address (registered).
- `write_data`  out  WIDTH  register-file write data (registered).
- `pend_mask`  out  N_REGS  bit i set while any write to register i is queued or presented on the output.
- `squash_cnt`  out  8  saturating count of squashed port B entries.

## Operation
- Port B accept: `b_fire = b_valid && b_ready`. `b_ready = (count < DEPTH)` and depends only on the current queue occupancy (no combinational path from `a_valid`).
- Issue selection each cycle, in priority order:
  1. `a_valid`: issue A.
  2. Queue non-empty: issue queue head (pop).
  3. `b_fire` with the queue empty: issue B directly (bypass, no push).
  4. Otherwise no issue.
- `b_fire` not consumed by rule 3 pushes `{b_addr, b_data}` at the queue tail. Push and pop in the same cycle are allowed. Full plus pop does not raise `b_ready` in that cycle.
- Ordering rule: same-cycle A and B are treated as A older, B younger. Anything already queued is older than a new A.
- Squash: when A issues to address X, every valid queue entry with address X is invalidated in the same posedge. An incoming same-cycle B to X is not squashed; it is enqueued and later overwrites.
- Invalidated entries are removed from the queue. Remaining entries keep their order, and `count` decreases by the number squashed (plus the pop, if any).
- `squash_cnt` increments by the number of entries squashed and saturates at 255.
- Output register: on issue, `RegWrite<=1`, `write_address`/`write_data` take the issued request's values. With no issue, `RegWrite<=0` and the address/data hold their previous values.
- `pend_mask` is combinational: the OR of one-hot(addr) over valid queue entries, plus one-hot(`write_address`) when `RegWrite=1`.

## Timing
- Reset (`rst=0`, async): queue emptied, `count=0`, `RegWrite=0`, `write_address=0`, `write_data=0`, `squash_cnt=0`. Consequently `b_ready=1` and `pend_mask=0` during reset.
- Reset asserted mid-operation discards all queued writes. No partial write is presented.
- Latency: an accepted A, or a bypassed B, appears on the outputs 1 cycle after acceptance. The register file commits it at the following negedge.
- A queued B issues in the first cycle with no `a_valid`.
- Worst-case starvation: B waits while `a_valid` stays high, and `b_ready=0` once the queue is full.
- Queue holds at most DEPTH entries; pointers wrap modulo DEPTH.
- Squash and pop of the same head entry in the same cycle cannot happen, because A issuing blocks pops.

## Test plan
- Reset then a lone B (addr 3, data 0x00AA): `b_ready=1`; next cycle `RegWrite=1`, `write_address=3`, `write_data=0x00AA`, `pend_mask=0x08`; the cycle after, `RegWrite=0`, `pend_mask=0`.
- Simultaneous A (r1, 0x1111) and B (r2, 0x2222): outputs show r1/0x1111 on cycle 1 and r2/0x2222 on cycle 2.
- `a_valid` held for 4 cycles while B sends r4 and r5 (DEPTH=2): `b_ready=0` after two accepts. After A drops, r4 issues, then r5, then `b_ready=1`.
- Queue holds B r6 = 0x0006. A writes r6 = 0x0A06: the entry is squashed, `squash_cnt=1`, r6 is written only with 0x0A06, and no later write to r6 occurs.
- Same cycle A r7 = 0x0001 and B r7 = 0x0002: A is written first, then B. Final register value 0x0002, `squash_cnt=0`.
- Assert `rst=0` with 2 entries queued and `RegWrite=1`: all outputs go to 0 immediately. After release, no stale write issues.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// Writeback bus: port A (always accepted), port B (valid/ready),
// register-file write outputs, pending mask and squash counter.
interface wb_write_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int N_REGS = 8,
  parameter int AW     = $clog2(N_REGS)
);
  logic             a_valid;
  logic [AW-1:0]    a_addr;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [AW-1:0]    b_addr;
  logic [WIDTH-1:0] b_data;
  logic             RegWrite;
  logic [AW-1:0]    write_address;
  logic [WIDTH-1:0] write_data;
  logic [N_REGS-1:0] pend_mask;
  logic [7:0]       squash_cnt;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output b_ready,
    output RegWrite, write_address, write_data,
    output pend_mask, squash_cnt
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  b_ready,
    input  RegWrite, write_address, write_data,
    input  pend_mask, squash_cnt
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Shares one register-file write port: A wins, B queues in order.
// Ports: clk, rst (async active-low), bus (wb_write_arbiter_if.slave).
module wb_write_arbiter #(
  parameter int WIDTH  = 16,
  parameter int N_REGS = 8,
  parameter int DEPTH  = 2
) (
  input  logic clk,
  input  logic rst,
  wb_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(N_REGS);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             q_q [DEPTH];
  ent_t             q_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic [AW-1:0]    wa_q, wa_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [7:0]       sc_q, sc_d;

  logic             b_rdy, b_fire;
  logic             pop, bypass, push;
  logic [DEPTH-1:0] live, hit, keep;
  int               rank [DEPTH];
  int               n, sq;
  logic [8:0]       sc_sum;

  // Occupancy only: no path from a_valid into b_ready.
  assign b_rdy       = cnt_q < CW'(DEPTH);
  assign bus.b_ready = b_rdy;

  always_comb begin
    b_fire = bus.b_valid && b_rdy;
    pop    = !bus.a_valid && (cnt_q != '0);
    bypass = b_fire && !bus.a_valid && (cnt_q == '0);
    push   = b_fire && !bypass;
    n      = 0;
    sq     = 0;
    live   = '0;
    hit    = '0;
    keep   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rank[i] = 0;
      live[i] = CW'(i) < cnt_q;
      hit[i]  = live[i] && bus.a_valid &&
                (q_q[i].addr == bus.a_addr);
      if (hit[i]) sq++;
      keep[i] = live[i] && !hit[i] && !(pop && i == 0);
      rank[i] = n;
      if (keep[i]) n++;
    end
    // Compact survivors to the front, then append the push.
    for (int k = 0; k < DEPTH; k++) begin
      q_d[k] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && rank[i] == k) q_d[k] = q_q[i];
      end
      if (push && n == k) begin
        q_d[k].addr = bus.b_addr;
        q_d[k].data = bus.b_data;
      end
    end
    cnt_d = CW'(n) + CW'(push);

    sc_sum = {1'b0, sc_q} + 9'(sq);
    sc_d   = sc_sum[8] ? 8'hFF : sc_sum[7:0];

    rw_d = 1'b1;
    wa_d = wa_q;
    wd_d = wd_q;
    if (bus.a_valid) begin
      wa_d = bus.a_addr;
      wd_d = bus.a_data;
    end else if (cnt_q != '0) begin
      wa_d = q_q[0].addr;
      wd_d = q_q[0].data;
    end else if (b_fire) begin
      wa_d = bus.b_addr;
      wd_d = bus.b_data;
    end else begin
      rw_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      cnt_q <= '0;
      rw_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      sc_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
      cnt_q <= cnt_d;
      rw_q  <= rw_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
      sc_q  <= sc_d;
    end
  end

  always_comb begin
    bus.pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt_q) bus.pend_mask[q_q[i].addr] = 1'b1;
    end
    if (rw_q) bus.pend_mask[wa_q] = 1'b1;
  end

  assign bus.RegWrite      = rw_q;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd_q;
  assign bus.squash_cnt    = sc_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter.
// Register-file model commits on negedge.
module tb_wb_write_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] rf [8];
  int   w6;

  wb_write_arbiter_if #(.WIDTH(16), .N_REGS(8)) bus ();

  wb_write_arbiter #(.WIDTH(16), .N_REGS(8), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.RegWrite) begin
      rf[bus.write_address] <= bus.write_data;
      if (bus.write_address == 3'd6) w6 <= w6 + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #12;
    checks += 6;
    if (bus.RegWrite !== 1'b0) begin errors++;
      $display("FAIL rst_rw got %b exp 0", bus.RegWrite); end
    if (bus.write_address !== 3'd0) begin errors++;
      $display("FAIL rst_wa got %0d exp 0", bus.write_address); end
    if (bus.write_data !== 16'h0) begin errors++;
      $display("FAIL rst_wd got %h exp 0", bus.write_data); end
    if (bus.pend_mask !== 8'h0) begin errors++;
      $display("FAIL rst_pm got %h exp 0", bus.pend_mask); end
    if (bus.squash_cnt !== 8'h0) begin errors++;
      $display("FAIL rst_sc got %0d exp 0", bus.squash_cnt); end
    if (bus.b_ready !== 1'b1) begin errors++;
      $display("FAIL rst_brdy got %b exp 1", bus.b_ready); end
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_lone_b();
    bus.b_valid = 1; bus.b_addr = 3; bus.b_data = 16'h00AA;
    checks++;
    if (bus.b_ready !== 1'b1) begin errors++;
      $display("FAIL lone_brdy got %b exp 1", bus.b_ready); end
    tick();
    idle();
    checks += 4;
    if (bus.RegWrite !== 1'b1) begin errors++;
      $display("FAIL lone_rw got %b exp 1", bus.RegWrite); end
    if (bus.write_address !== 3'd3) begin errors++;
      $display("FAIL lone_wa got %0d exp 3", bus.write_address); end
    if (bus.write_data !== 16'h00AA) begin errors++;
      $display("FAIL lone_wd got %h exp 00aa", bus.write_data); end
    if (bus.pend_mask !== 8'h08) begin errors++;
      $display("FAIL lone_pm got %h exp 08", bus.pend_mask); end
    tick();
    checks += 2;
    if (bus.RegWrite !== 1'b0) begin errors++;
      $display("FAIL lone_rw2 got %b exp 0", bus.RegWrite); end
    if (bus.pend_mask !== 8'h00) begin errors++;
      $display("FAIL lone_pm2 got %h exp 00", bus.pend_mask); end
  endtask

  task automatic test_simul();
    bus.a_valid = 1; bus.a_addr = 1; bus.a_data = 16'h1111;
    bus.b_valid = 1; bus.b_addr = 2; bus.b_data = 16'h2222;
    tick();
    idle();
    checks += 3;
    if (bus.RegWrite !== 1'b1 || bus.write_address !== 3'd1 ||
        bus.write_data !== 16'h1111) begin errors++;
      $display("FAIL sim_c1 got %b/%0d/%h exp 1/1/1111",
               bus.RegWrite, bus.write_address, bus.write_data); end
    if (bus.pend_mask !== 8'h06) begin errors++;
      $display("FAIL sim_pm got %h exp 06", bus.pend_mask); end
    if (bus.b_ready !== 1'b1) begin errors++;
      $display("FAIL sim_brdy got %b exp 1", bus.b_ready); end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.write_address !== 3'd2 ||
        bus.write_data !== 16'h2222) begin errors++;
      $display("FAIL sim_c2 got %b/%0d/%h exp 1/2/2222",
               bus.RegWrite, bus.write_address, bus.write_data); end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b0) begin errors++;
      $display("FAIL sim_c3 got %b exp 0", bus.RegWrite); end
  endtask

  task automatic test_starve();
    bus.a_valid = 1; bus.a_addr = 0; bus.a_data = 16'h00A0;
    bus.b_valid = 1; bus.b_addr = 4; bus.b_data = 16'h0044;
    checks++;
    if (bus.b_ready !== 1'b1) begin errors++;
      $display("FAIL stv_rdy0 got %b exp 1", bus.b_ready); end
    tick();
    bus.a_data = 16'h00A1;
    bus.b_addr = 5; bus.b_data = 16'h0055;
    checks++;
    if (bus.b_ready !== 1'b1) begin errors++;
      $display("FAIL stv_rdy1 got %b exp 1", bus.b_ready); end
    tick();
    bus.a_data = 16'h00A2;
    bus.b_valid = 0;
    checks += 2;
    if (bus.b_ready !== 1'b0) begin errors++;
      $display("FAIL stv_rdy2 got %b exp 0", bus.b_ready); end
    if (bus.pend_mask !== 8'h31) begin errors++;
      $display("FAIL stv_pm got %h exp 31", bus.pend_mask); end
    tick();
    bus.a_data = 16'h00A3;
    checks++;
    if (bus.b_ready !== 1'b0) begin errors++;
      $display("FAIL stv_rdy3 got %b exp 0", bus.b_ready); end
    tick();
    idle();
    checks++;
    if (bus.write_address !== 3'd0 || bus.write_data !== 16'h00A3)
    begin errors++;
      $display("FAIL stv_a got %0d/%h exp 0/00a3",
               bus.write_address, bus.write_data); end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.write_address !== 3'd4 ||
        bus.write_data !== 16'h0044) begin errors++;
      $display("FAIL stv_r4 got %b/%0d/%h exp 1/4/0044",
               bus.RegWrite, bus.write_address, bus.write_data); end
    tick();
    checks += 2;
    if (bus.RegWrite !== 1'b1 || bus.write_address !== 3'd5 ||
        bus.write_data !== 16'h0055) begin errors++;
      $display("FAIL stv_r5 got %b/%0d/%h exp 1/5/0055",
               bus.RegWrite, bus.write_address, bus.write_data); end
    if (bus.b_ready !== 1'b1) begin errors++;
      $display("FAIL stv_rdy_end got %b exp 1", bus.b_ready); end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b0) begin errors++;
      $display("FAIL stv_idle got %b exp 0", bus.RegWrite); end
  endtask

  task automatic test_squash();
    w6 = 0;
    bus.a_valid = 1; bus.a_addr = 0; bus.a_data = 16'h0B00;
    bus.b_valid = 1; bus.b_addr = 6; bus.b_data = 16'h0006;
    tick();
    bus.a_addr = 6; bus.a_data = 16'h0A06;
    bus.b_valid = 0;
    checks++;
    if (bus.pend_mask !== 8'h41) begin errors++;
      $display("FAIL sq_pm0 got %h exp 41", bus.pend_mask); end
    tick();
    idle();
    checks += 3;
    if (bus.squash_cnt !== 8'd1) begin errors++;
      $display("FAIL sq_cnt got %0d exp 1", bus.squash_cnt); end
    if (bus.write_address !== 3'd6 || bus.write_data !== 16'h0A06)
    begin errors++;
      $display("FAIL sq_out got %0d/%h exp 6/0a06",
               bus.write_address, bus.write_data); end
    if (bus.pend_mask !== 8'h40) begin errors++;
      $display("FAIL sq_pm1 got %h exp 40", bus.pend_mask); end
    repeat (3) tick();
    checks += 3;
    if (rf[6] !== 16'h0A06) begin errors++;
      $display("FAIL sq_rf got %h exp 0a06", rf[6]); end
    if (w6 != 1) begin errors++;
      $display("FAIL sq_w6 got %0d exp 1", w6); end
    if (bus.pend_mask !== 8'h00) begin errors++;
      $display("FAIL sq_pm2 got %h exp 00", bus.pend_mask); end
  endtask

  task automatic test_same_reg();
    rst = 0;
    #3;
    rst = 1;
    tick();
    bus.a_valid = 1; bus.a_addr = 7; bus.a_data = 16'h0001;
    bus.b_valid = 1; bus.b_addr = 7; bus.b_data = 16'h0002;
    tick();
    idle();
    checks += 2;
    if (bus.write_address !== 3'd7 || bus.write_data !== 16'h0001)
    begin errors++;
      $display("FAIL same_c1 got %0d/%h exp 7/0001",
               bus.write_address, bus.write_data); end
    if (bus.pend_mask !== 8'h80) begin errors++;
      $display("FAIL same_pm got %h exp 80", bus.pend_mask); end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.write_data !== 16'h0002)
    begin errors++;
      $display("FAIL same_c2 got %b/%h exp 1/0002",
               bus.RegWrite, bus.write_data); end
    tick();
    checks += 2;
    if (rf[7] !== 16'h0002) begin errors++;
      $display("FAIL same_rf got %h exp 0002", rf[7]); end
    if (bus.squash_cnt !== 8'd0) begin errors++;
      $display("FAIL same_sc got %0d exp 0", bus.squash_cnt); end
  endtask

  task automatic test_mid_reset();
    bus.a_valid = 1; bus.a_addr = 1; bus.a_data = 16'h0101;
    bus.b_valid = 1; bus.b_addr = 2; bus.b_data = 16'h0202;
    tick();
    bus.b_addr = 3; bus.b_data = 16'h0303;
    tick();
    idle();
    checks++;
    if (bus.b_ready !== 1'b0 || bus.RegWrite !== 1'b1) begin errors++;
      $display("FAIL mr_pre got rdy %b rw %b exp 0 1",
               bus.b_ready, bus.RegWrite); end
    rst = 0;
    #1;
    checks += 4;
    if (bus.RegWrite !== 1'b0 || bus.write_address !== 3'd0 ||
        bus.write_data !== 16'h0) begin errors++;
      $display("FAIL mr_out got %b/%0d/%h exp 0/0/0000",
               bus.RegWrite, bus.write_address, bus.write_data); end
    if (bus.pend_mask !== 8'h00) begin errors++;
      $display("FAIL mr_pm got %h exp 00", bus.pend_mask); end
    if (bus.b_ready !== 1'b1) begin errors++;
      $display("FAIL mr_rdy got %b exp 1", bus.b_ready); end
    if (bus.squash_cnt !== 8'd0) begin errors++;
      $display("FAIL mr_sc got %0d exp 0", bus.squash_cnt); end
    #2;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.RegWrite !== 1'b0) begin errors++;
        $display("FAIL mr_stale%0d got %b exp 0", i, bus.RegWrite); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    w6 = 0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    rst = 1;
    idle();
    test_reset();
    test_lone_b();
    test_simul();
    test_starve();
    test_squash();
    test_same_reg();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
